// File: rtl/nibble_serial_adder.sv
// Purpose : WIDTH-bit adder built from one shared 4-bit slice, LS nibble first, registered carry between nibbles.
// Latency : accept on edge 0, nibbles on edges 1..N, done pulses for the cycle after edge N, idle again after edge N+1.
// Backpressure: no queueing; start is only sampled in IDLE, so the requester waits for busy=0.
// Optional subtract (sub port, A - B) is built when SERIAL_ADDER_SUB_EN is defined.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand B and initial carry as seen at the accepting edge; subtract
  // is A + ~B + 1, so the carry-out doubles as a "no borrow" flag.
  logic [WIDTH-1:0] b_in;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = op_b;
  assign c_in = cin;
`endif

  // Bit offset of the current nibble and the shared 4+4+1 -> 5 bit slice add.
  logic [IDX_W+1:0] nib_base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;

  // Select the active nibble of each operand and add it with the held carry.
  always_comb begin
    nib_base = {idx_q, 2'b00};
    a_nib    = a_q[nib_base +: 4];
    b_nib    = b_q[nib_base +: 4];
    slice    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Capture everything here so later input changes cannot leak in.
          state_d = S_RUN;
          a_d     = op_a;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        sum_d[nib_base +: 4] = slice[3:0];
        carry_d              = slice[4];
        if (idx_q == LAST_IDX) begin
          // cout only changes here, so it holds the previous result until now.
          cout_d  = slice[4];
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Every output comes straight from a flop.
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16): directed and random operations
// checked against an arithmetic reference model, including timing, reset abort
// and ignored in-flight starts; subtract cases when SERIAL_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  int   checks = 0;
  int   errors = 0;
  logic prev_cout = 1'b0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} = A + B + cin, or for subtract sum = A - B with cout = no borrow.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic ci, input logic sb);
    logic [WIDTH-1:0] diff;
    if (sb) begin
      diff  = a - b;
      model = {(a >= b), diff};
    end else begin
      model = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    end
  endfunction

  // Issue one operation from idle (called #1 after a rising edge) and check
  // every cycle up to the return to idle. hammer keeps start asserted with
  // other operands throughout the busy window.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic sb, input logic hammer);
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] mask;
    exp  = model(a, b, ci, sb);
    op_a = a;
    op_b = b;
    cin  = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub  = sb;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = hammer;
    op_a  = hammer ? 16'h00FF : WIDTH'($urandom);
    op_b  = hammer ? 16'h00FF : WIDTH'($urandom);
    cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'($urandom);
`endif
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
    chk("accept_sum_cleared", sum, 0);
    chk("accept_cout_hold", cout, prev_cout);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      mask = WIDTH'((32'h1 << (4 * k)) - 1);
      chk("run_busy", busy, 1);
      chk("run_partial_sum", sum, exp[WIDTH-1:0] & mask);
      if (k < N) begin
        chk("run_done_low", done, 0);
        chk("run_cout_hold", cout, prev_cout);
      end else begin
        chk("done_pulse", done, 1);
        chk("final_cout", cout, exp[WIDTH]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_released", busy, 0);
    chk("sum_hold", sum, exp[WIDTH-1:0]);
    chk("cout_hold", cout, exp[WIDTH]);
    prev_cout = exp[WIDTH];
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // Directed additions.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Starts during busy are ignored; exactly one done pulse is checked inside.
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("no_queued_accept", busy, 0);

    // Leave cout=1 behind, then abort an operation with reset.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", busy, 0);
    prev_cout = 1'b0;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);

    // Random additions.
    for (int i = 0; i < 24; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
